// File: rtl/nes_oam_dma.sv
// NES-style OAM DMA engine: a $4014 write halts the CPU and copies 256 bytes from page:00..FF to $2004.
// Optional OAM_DMA_RESTART_EN lets a $4014 write during a transfer restart it from the new page.
module nes_oam_dma (
  input  logic        clk,
  input  logic        b_rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  input  logic [7:0]  bus_rdata,
  output logic        bus_wr,
  output logic [7:0]  bus_wdata,
  output logic        dma_active,
  output logic        dma_done
);

  // state | meaning
  // IDLE  | CPU runs, waiting for a $4014 write
  // HALT  | first halted cycle after the trigger
  // ALIGN | one-cycle wait so READ starts on an even cycle
  // READ  | fetch byte at {page,cnt} into the latch
  // WRITE | store latched byte to $2004, advance cnt
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

`ifdef OAM_DMA_RESTART_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        cyc_odd_q, cyc_odd_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  latch_q, latch_d;
  logic        done_q, done_d;
  logic        trig;

  assign trig = cpu_wr && (cpu_addr == 16'h4014);

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      state_q   <= IDLE;
      cyc_odd_q <= 1'b0;
      page_q    <= 8'h00;
      cnt_q     <= 8'h00;
      latch_q   <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_odd_q <= cyc_odd_d;
      page_q    <= page_d;
      cnt_q     <= cnt_d;
      latch_q   <= latch_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cyc_odd_d = ~cyc_odd_q;
    page_d    = page_q;
    cnt_d     = cnt_q;
    latch_d   = latch_q;
    done_d    = 1'b0;
    bus_addr  = 16'h0000;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_wdata = 8'h00;
    case (state_q)
      IDLE: begin
        if (trig) begin
          page_d  = cpu_wdata;
          cnt_d   = 8'h00;
          state_d = HALT;
        end
      end
      // cyc_odd flips at the edge, so odd now means READ lands on an even cycle
      HALT:  state_d = cyc_odd_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        bus_addr = {page_q, cnt_q};
        bus_rd   = 1'b1;
        latch_d  = bus_rdata;
        state_d  = WRITE;
      end
      WRITE: begin
        bus_addr  = 16'h2004;
        bus_wr    = 1'b1;
        bus_wdata = latch_q;
        if (cnt_q == 8'hFF) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (RESTART_EN && trig && (state_q != IDLE)) begin
      page_d  = cpu_wdata;
      cnt_d   = 8'h00;
      state_d = HALT;
      done_d  = 1'b0;
    end
  end

  assign cpu_rdy    = (state_q == IDLE);
  assign dma_active = (state_q != IDLE);
  assign dma_done   = done_q;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed bench for nes_oam_dma: alignment, data path, mid-transfer reset, re-trigger, non-trigger traffic.
module tb_nes_oam_dma;
  logic        clk = 1'b0;
  logic        b_rst = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic [7:0]  bus_rdata;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic        dma_active;
  logic        dma_done;

  int vectors = 0;
  int miscompares = 0;
  logic tb_odd;

  nes_oam_dma dut (
    .clk(clk), .b_rst(b_rst), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdy(cpu_rdy), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_rdata(bus_rdata),
    .bus_wr(bus_wr), .bus_wdata(bus_wdata), .dma_active(dma_active), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  // memory: byte at xxNN = NN ^ A5
  assign bus_rdata = bus_rd ? (bus_addr[7:0] ^ 8'hA5) : 8'h00;

  // independent cycle-parity model, cleared by reset like the DUT's
  always @(posedge clk or negedge b_rst)
    if (!b_rst) tb_odd <= 1'b0;
    else        tb_odd <= ~tb_odd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cpu_rdy"}, cpu_rdy, 1);
    chk({tag, "_active"}, dma_active, 0);
    chk({tag, "_done"}, dma_done, 0);
    chk({tag, "_bus"}, {bus_addr, bus_rd, bus_wr, bus_wdata}, 0);
  endtask

  // drive a $4014 write in a cycle whose parity yields the wanted HALT alignment
  task automatic trigger(input logic [7:0] page, input bit want_align, input string tag);
    int guard = 0;
    while (tb_odd !== want_align && guard < 4) begin
      tick();
      guard++;
    end
    cpu_addr = 16'h4014; cpu_wr = 1'b1; cpu_wdata = page;
    #1;
    chk({tag, "_trig_rdy"}, cpu_rdy, 1);
    tick();
    cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    chk({tag, "_halt_rdy"}, cpu_rdy, 0);
    chk({tag, "_halt_active"}, dma_active, 1);
  endtask

  // follow a transfer from the current halted cycle until the CPU runs again
  task automatic collect(input string tag, input int exp_cycles, input int exp_first_idx,
                         input logic [15:0] exp_first, input logic [15:0] exp_last,
                         input int exp_writes, input logic [7:0] start);
    int cyc = 0;
    int nwr = 0;
    int nrd = 0;
    int first_idx = -1;
    int bad_wr_addr = 0;
    logic [15:0] first = 16'h0000;
    logic [15:0] last = 16'h0000;
    logic [7:0] e;
    while (cpu_rdy === 1'b0 && cyc < 1000) begin
      if (bus_rd === 1'b1) begin
        if (nrd == 0) begin first = bus_addr; first_idx = cyc; end
        last = bus_addr;
        nrd++;
      end
      if (bus_wr === 1'b1) begin
        if (bus_addr !== 16'h2004) bad_wr_addr++;
        e = (start + nwr[7:0]) ^ 8'hA5;
        chk($sformatf("%s_wdata%0d", tag, nwr), bus_wdata, e);
        nwr++;
      end
      cyc++;
      tick();
    end
    chk({tag, "_halt_cycles"}, cyc, exp_cycles);
    if (exp_first_idx >= 0) chk({tag, "_first_rd_idx"}, first_idx, exp_first_idx);
    chk({tag, "_first_rd_addr"}, first, exp_first);
    chk({tag, "_last_rd_addr"}, last, exp_last);
    chk({tag, "_writes"}, nwr, exp_writes);
    chk({tag, "_wr_addr_bad"}, bad_wr_addr, 0);
    chk({tag, "_done_pulse"}, dma_done, 1);
    chk({tag, "_end_rdy"}, cpu_rdy, 1);
    tick();
    chk({tag, "_done_clear"}, dma_done, 0);
  endtask

  initial begin
    int guard;
    bit al;
    // reset state
    #3;
    chk_idle_outputs("reset");
    #20;
    @(posedge clk); #1;
    b_rst = 1'b1;
    tick();
    chk_idle_outputs("after_reset");

    // non-trigger traffic
    cpu_addr = 16'h4015; cpu_wr = 1'b1; cpu_wdata = 8'h02;
    tick();
    chk_idle_outputs("wr4015");
    cpu_addr = 16'h2004;
    tick();
    chk_idle_outputs("wr2004");
    cpu_addr = 16'h4014; cpu_wr = 1'b0;
    tick();
    chk_idle_outputs("rd4014");
    tick();
    chk_idle_outputs("rd4014_b");
    cpu_addr = 16'h0000; cpu_wdata = 8'h00;

    // even-aligned: HALT cycle odd -> READ next, 513 halted cycles
    trigger(8'h02, 1'b0, "even");
    collect("even", 513, 1, 16'h0200, 16'h02FF, 256, 8'h00);

    // odd-aligned with the page-7 data pattern: one ALIGN cycle, 514 halted cycles
    tick();
    trigger(8'h07, 1'b1, "odd");
    collect("odd", 514, 2, 16'h0700, 16'h07FF, 256, 8'h00);

    // reset mid-transfer at cnt=100
    tick();
    trigger(8'h02, 1'b0, "rst");
    guard = 0;
    while (!(bus_rd === 1'b1 && bus_addr === 16'h0264) && guard < 600) begin
      tick();
      guard++;
    end
    chk("rst_reach_cnt100", bus_addr, 16'h0264);
    b_rst = 1'b0;
    #1;
    chk_idle_outputs("rst_mid");
    tick();
    tick();
    b_rst = 1'b1;
    guard = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_rd !== 1'b0 || bus_wr !== 1'b0 || cpu_rdy !== 1'b1) guard++;
    end
    chk("rst_no_strobes", guard, 0);

    // re-trigger with page 03 while reading cnt=50 of page 02
    trigger(8'h02, 1'b0, "retrig");
    guard = 0;
    while (!(bus_rd === 1'b1 && bus_addr === 16'h0232) && guard < 600) begin
      tick();
      guard++;
    end
    chk("retrig_reach_cnt50", bus_addr, 16'h0232);
    cpu_addr = 16'h4014; cpu_wr = 1'b1; cpu_wdata = 8'h03;
    tick();
    cpu_addr = 16'h0000; cpu_wr = 1'b0; cpu_wdata = 8'h00;
`ifdef OAM_DMA_RESTART_EN
    al = (tb_odd == 1'b0);
    collect("retrig", al ? 514 : 513, al ? 2 : 1, 16'h0300, 16'h03FF, 256, 8'h00);
`else
    al = 1'b0;
    collect("retrig", 411, -1, 16'h0233, 16'h02FF, 206, 8'h32);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
